// File: rtl/ctrl_pipe_dec_pkg.sv
// Shared control-decode definitions: opcodes, ALU and regdst codes, per-stage field bundles.
// Pure declarations; imported by the decoder and anything that inspects its stage contents.
package ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // Each stage bundle nests the bundle of the stage after it, so a stage simply forwards its tail.
  typedef struct packed {
    logic valid;
    logic illegal;
    logic regwrite;
    logic memtoreg;
    logic jal;
  } ctrl_w_t;

  typedef struct packed {
    ctrl_w_t w;
    logic    memwrite;
  } ctrl_m_t;

  typedef struct packed {
    ctrl_m_t    m;
    logic       alusrc;
    logic [1:0] regdst;
    logic [2:0] aluop;
  } ctrl_e_t;

endpackage

// File: rtl/ctrl_pipe_dec_if.sv
// Decoder bundle: ID opcode/valid and per-stage stall/flush in, per-stage decoded controls out.
// Master is the pipeline/hazard side, slave is ctrl_pipe_dec.
interface ctrl_pipe_dec_if #(
  parameter int ALUOP_W  = 3,
  parameter int ILLCNT_W = 8
);
  logic [5:0]          opD;
  logic                validD;
  logic                stallE;
  logic                flushE;
  logic                stallM;
  logic                flushM;
  logic                regwriteD;
  logic                branchD;
  logic                branchneD;
  logic                jumpD;
  logic                jalD;
  logic                zeroextD;
  logic                regwriteE;
  logic                alusrcE;
  logic                memtoregE;
  logic                jalE;
  logic [1:0]          regdstE;
  logic [ALUOP_W-1:0]  aluopE;
  logic                regwriteM;
  logic                memwriteM;
  logic                memtoregM;
  logic                regwriteW;
  logic                memtoregW;
  logic                jalW;
  logic                illegalW;
  logic [ILLCNT_W-1:0] illcnt;

  modport master (
    output opD, validD, stallE, flushE, stallM, flushM,
    input  regwriteD, branchD, branchneD, jumpD, jalD, zeroextD,
    input  regwriteE, alusrcE, memtoregE, jalE, regdstE, aluopE,
    input  regwriteM, memwriteM, memtoregM,
    input  regwriteW, memtoregW, jalW, illegalW, illcnt
  );

  modport slave (
    input  opD, validD, stallE, flushE, stallM, flushM,
    output regwriteD, branchD, branchneD, jumpD, jalD, zeroextD,
    output regwriteE, alusrcE, memtoregE, jalE, regdstE, aluopE,
    output regwriteM, memwriteM, memtoregM,
    output regwriteW, memtoregW, jalW, illegalW, illcnt
  );
endinterface

// File: rtl/ctrl_pipe_dec_stage_reg.sv
// Pipeline control register with asynchronous clear, synchronous flush (bubble) and hold.
// Latency: 1 cycle. Backpressure: hold freezes the contents; flush wins over hold.
module ctrl_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ctrl_pipe_dec.sv
// Main control decoder for the 5-stage core: ID decode carried through ID/EX, EX/MEM, MEM/WB.
// Latency: 1 cycle per stage. Backpressure: stallE/stallM hold their stage; flush inserts a bubble.
module ctrl_pipe_dec
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W  = 3,
  parameter int ILLCNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  ctrl_pipe_dec_if.slave bus
);

  ctrl_e_t             ctrlD;
  ctrl_e_t             ctrlE;
  ctrl_m_t             ctrlM;
  ctrl_w_t             ctrlW;
  logic                branchD;
  logic                branchneD;
  logic                jumpD;
  logic                zeroextD;
  logic                loadE;
  logic                bubbleM;
  logic                validE;
  logic                validM;
  logic                validW;
  logic                illSticky;
  logic [ILLCNT_W-1:0] illCnt;

  always_comb begin
    ctrlD     = '0;
    branchD   = 1'b0;
    branchneD = 1'b0;
    jumpD     = 1'b0;
    zeroextD  = 1'b0;
    if (bus.validD) begin
      ctrlD.m.w.valid = 1'b1;
      case (bus.opD)
        OP_R: begin
          ctrlD.m.w.regwrite = 1'b1;
          ctrlD.regdst       = RD_RD;
          ctrlD.aluop        = ALU_FUNCT;
        end
        OP_LW: begin
          ctrlD.m.w.regwrite = 1'b1;
          ctrlD.m.w.memtoreg = 1'b1;
          ctrlD.alusrc       = 1'b1;
          ctrlD.aluop        = ALU_ADD;
        end
        OP_SW: begin
          ctrlD.m.memwrite = 1'b1;
          ctrlD.alusrc     = 1'b1;
          ctrlD.aluop      = ALU_ADD;
        end
        OP_BEQ: begin
          branchD     = 1'b1;
          ctrlD.aluop = ALU_SUB;
        end
        OP_BNE: begin
          branchD     = 1'b1;
          branchneD   = 1'b1;
          ctrlD.aluop = ALU_SUB;
        end
        OP_ADDI: begin
          ctrlD.m.w.regwrite = 1'b1;
          ctrlD.alusrc       = 1'b1;
          ctrlD.aluop        = ALU_ADD;
        end
        OP_ANDI: begin
          ctrlD.m.w.regwrite = 1'b1;
          ctrlD.alusrc       = 1'b1;
          zeroextD           = 1'b1;
          ctrlD.aluop        = ALU_AND;
        end
        OP_ORI: begin
          ctrlD.m.w.regwrite = 1'b1;
          ctrlD.alusrc       = 1'b1;
          zeroextD           = 1'b1;
          ctrlD.aluop        = ALU_OR;
        end
        OP_SLTI: begin
          ctrlD.m.w.regwrite = 1'b1;
          ctrlD.alusrc       = 1'b1;
          ctrlD.aluop        = ALU_SLT;
        end
        OP_LUI: begin
          ctrlD.m.w.regwrite = 1'b1;
          ctrlD.alusrc       = 1'b1;
          ctrlD.aluop        = ALU_LUI;
        end
        OP_J: begin
          jumpD = 1'b1;
        end
        OP_JAL: begin
          jumpD              = 1'b1;
          ctrlD.m.w.jal      = 1'b1;
          ctrlD.m.w.regwrite = 1'b1;
          ctrlD.regdst       = RD_RA;
        end
        default: begin
          ctrlD.m.w.illegal = 1'b1;
        end
      endcase
    end
  end

  // A stalled EX stage must not replay its instruction into MEM, unless MEM is itself frozen.
  assign bubbleM = bus.flushM | (bus.stallE & ~bus.stallM);

  ctrl_stage_reg #(.W($bits(ctrl_e_t))) u_idEx (
    .clk   (clk),
    .rst   (rst),
    .hold  (bus.stallE),
    .flush (bus.flushE),
    .d     (ctrlD),
    .q     (ctrlE)
  );

  ctrl_stage_reg #(.W($bits(ctrl_m_t))) u_exMem (
    .clk   (clk),
    .rst   (rst),
    .hold  (bus.stallM),
    .flush (bubbleM),
    .d     (ctrlE.m),
    .q     (ctrlM)
  );

  ctrl_stage_reg #(.W($bits(ctrl_w_t))) u_memWb (
    .clk   (clk),
    .rst   (rst),
    .hold  (1'b0),
    .flush (1'b0),
    .d     (ctrlM.w),
    .q     (ctrlW)
  );

  // Count only on edges that actually load ID/EX, so a held illegal op is counted once.
  assign loadE = ~bus.flushE & ~bus.stallE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illCnt <= '0;
    end else if (loadE && ctrlD.m.w.illegal && (illCnt != '1)) begin
      illCnt <= illCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illSticky <= 1'b0;
    end else if (validW && ctrlW.illegal) begin
      illSticky <= 1'b1;
    end
  end

  assign validE = ctrlE.m.w.valid;
  assign validM = ctrlM.w.valid;
  assign validW = ctrlW.valid;

  assign bus.regwriteD = ctrlD.m.w.regwrite;
  assign bus.branchD   = branchD;
  assign bus.branchneD = branchneD;
  assign bus.jumpD     = jumpD;
  assign bus.jalD      = ctrlD.m.w.jal;
  assign bus.zeroextD  = zeroextD;

  assign bus.regwriteE = validE & ctrlE.m.w.regwrite;
  assign bus.alusrcE   = validE & ctrlE.alusrc;
  assign bus.memtoregE = validE & ctrlE.m.w.memtoreg;
  assign bus.jalE      = validE & ctrlE.m.w.jal;
  assign bus.regdstE   = validE ? ctrlE.regdst : RD_RT;
  assign bus.aluopE    = validE ? ALUOP_W'(ctrlE.aluop) : '0;

  assign bus.regwriteM = validM & ctrlM.w.regwrite;
  assign bus.memwriteM = validM & ctrlM.memwrite;
  assign bus.memtoregM = validM & ctrlM.w.memtoreg;

  assign bus.regwriteW = validW & ctrlW.regwrite;
  assign bus.memtoregW = validW & ctrlW.memtoreg;
  assign bus.jalW      = validW & ctrlW.jal;
  assign bus.illegalW  = illSticky | (validW & ctrlW.illegal);
  assign bus.illcnt    = illCnt;

endmodule

// File: tb/tb_ctrl_pipe_dec.sv
// Directed bench for ctrl_pipe_dec: stimulus queues per-cycle expectations, a monitor checks them.
`timescale 1ns/1ps
module tb_ctrl_pipe_dec;
  import ctrl_pkg::*;

  localparam int ALUOP_W  = 4;
  localparam int ILLCNT_W = 2;

  localparam int S_RWD = 0, S_BRD = 1, S_BNED = 2, S_JD = 3, S_JALD = 4, S_ZXD = 5;
  localparam int S_RWE = 6, S_ASE = 7, S_MRE = 8, S_JALE = 9, S_RDE = 10, S_ALUE = 11;
  localparam int S_RWM = 12, S_MWM = 13, S_MRM = 14;
  localparam int S_RWW = 15, S_MRW = 16, S_JALW = 17, S_ILLW = 18, S_ILLCNT = 19;

  typedef struct {
    int          at;
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   nChecks = 0;
  int   nFails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ctrl_pipe_dec_if #(.ALUOP_W(ALUOP_W), .ILLCNT_W(ILLCNT_W)) bus ();

  ctrl_pipe_dec #(.ALUOP_W(ALUOP_W), .ILLCNT_W(ILLCNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] sample(input int s);
    case (s)
      S_RWD:    return 32'(bus.regwriteD);
      S_BRD:    return 32'(bus.branchD);
      S_BNED:   return 32'(bus.branchneD);
      S_JD:     return 32'(bus.jumpD);
      S_JALD:   return 32'(bus.jalD);
      S_ZXD:    return 32'(bus.zeroextD);
      S_RWE:    return 32'(bus.regwriteE);
      S_ASE:    return 32'(bus.alusrcE);
      S_MRE:    return 32'(bus.memtoregE);
      S_JALE:   return 32'(bus.jalE);
      S_RDE:    return 32'(bus.regdstE);
      S_ALUE:   return 32'(bus.aluopE);
      S_RWM:    return 32'(bus.regwriteM);
      S_MWM:    return 32'(bus.memwriteM);
      S_MRM:    return 32'(bus.memtoregM);
      S_RWW:    return 32'(bus.regwriteW);
      S_MRW:    return 32'(bus.memtoregW);
      S_JALW:   return 32'(bus.jalW);
      S_ILLW:   return 32'(bus.illegalW);
      default:  return 32'(bus.illcnt);
    endcase
  endfunction

  function automatic string sigName(input int s);
    case (s)
      S_RWD:    return "regwriteD";
      S_BRD:    return "branchD";
      S_BNED:   return "branchneD";
      S_JD:     return "jumpD";
      S_JALD:   return "jalD";
      S_ZXD:    return "zeroextD";
      S_RWE:    return "regwriteE";
      S_ASE:    return "alusrcE";
      S_MRE:    return "memtoregE";
      S_JALE:   return "jalE";
      S_RDE:    return "regdstE";
      S_ALUE:   return "aluopE";
      S_RWM:    return "regwriteM";
      S_MWM:    return "memwriteM";
      S_MRM:    return "memtoregM";
      S_RWW:    return "regwriteW";
      S_MRW:    return "memtoregW";
      S_JALW:   return "jalW";
      S_ILLW:   return "illegalW";
      default:  return "illcnt";
    endcase
  endfunction

  // Monitor: every falling edge, check whatever the scoreboard expects for this cycle.
  always @(negedge clk) begin
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].at == cyc) begin
        nChecks++;
        if (sample(sb[k].sig) !== sb[k].val) begin
          nFails++;
          $display("FAIL %s @cycle %0d: got %0d, expected %0d",
                   sigName(sb[k].sig), cyc, sample(sb[k].sig), sb[k].val);
        end
        sb.delete(k);
      end
    end
  end

  task automatic ex(input int at, input int s, input int v);
    exp_t e;
    e.at  = at;
    e.sig = s;
    e.val = 32'(v);
    sb.push_back(e);
  endtask

  task automatic expD(input int at, input bit rw, br, bne, j, jal, zx);
    ex(at, S_RWD, rw); ex(at, S_BRD, br); ex(at, S_BNED, bne);
    ex(at, S_JD, j); ex(at, S_JALD, jal); ex(at, S_ZXD, zx);
  endtask

  task automatic expE(input int at, input bit rw, as, mr, jal, input int rd, input int alu);
    ex(at, S_RWE, rw); ex(at, S_ASE, as); ex(at, S_MRE, mr);
    ex(at, S_JALE, jal); ex(at, S_RDE, rd); ex(at, S_ALUE, alu);
  endtask

  task automatic expM(input int at, input bit rw, mw, mr);
    ex(at, S_RWM, rw); ex(at, S_MWM, mw); ex(at, S_MRM, mr);
  endtask

  task automatic expW(input int at, input bit rw, mr, jal);
    ex(at, S_RWW, rw); ex(at, S_MRW, mr); ex(at, S_JALW, jal);
  endtask

  task automatic drv(input logic [5:0] op, input logic v, input logic sE = 1'b0,
                     input logic fE = 1'b0, input logic sM = 1'b0, input logic fM = 1'b0);
    bus.opD    = op;
    bus.validD = v;
    bus.stallE = sE;
    bus.flushE = fE;
    bus.stallM = sM;
    bus.flushM = fM;
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int c;
    rst = 1'b1;
    drv(6'd0, 1'b0);
    tick(2);

    // Reset state
    c = cyc;
    expD(c, 0, 0, 0, 0, 0, 0); expE(c, 0, 0, 0, 0, 0, 0); expM(c, 0, 0, 0); expW(c, 0, 0, 0);
    ex(c, S_ILLW, 0); ex(c, S_ILLCNT, 0);
    tick();
    rst = 1'b0;
    tick();

    // LW, SW, R, BEQ back to back
    c = cyc;
    drv(OP_LW, 1'b1);
    expD(c, 1, 0, 0, 0, 0, 0); expE(c + 1, 1, 1, 1, 0, 0, 0); expM(c + 2, 1, 0, 1); expW(c + 3, 1, 1, 0);
    tick();
    drv(OP_SW, 1'b1);
    expD(c + 1, 0, 0, 0, 0, 0, 0); expE(c + 2, 0, 1, 0, 0, 0, 0); expM(c + 3, 0, 1, 0); expW(c + 4, 0, 0, 0);
    tick();
    drv(OP_R, 1'b1);
    expD(c + 2, 1, 0, 0, 0, 0, 0); expE(c + 3, 1, 0, 0, 0, 1, 2); expM(c + 4, 1, 0, 0); expW(c + 5, 1, 0, 0);
    tick();
    drv(OP_BEQ, 1'b1);
    expD(c + 3, 0, 1, 0, 0, 0, 0); expE(c + 4, 0, 0, 0, 0, 0, 1); expM(c + 5, 0, 0, 0); expW(c + 6, 0, 0, 0);
    tick();
    drv(6'd0, 1'b0);
    tick(4);

    // Extended opcodes and validD gating
    c = cyc;
    drv(OP_JAL, 1'b1);
    expD(c, 1, 0, 0, 1, 1, 0); expE(c + 1, 1, 0, 0, 1, 2, 0); expM(c + 2, 1, 0, 0); expW(c + 3, 1, 0, 1);
    tick();
    c = cyc; drv(OP_ORI, 1'b1);  expD(c, 1, 0, 0, 0, 0, 1); expE(c + 1, 1, 1, 0, 0, 0, 4); tick();
    c = cyc; drv(OP_BNE, 1'b1);  expD(c, 0, 1, 1, 0, 0, 0); expE(c + 1, 0, 0, 0, 0, 0, 1); tick();
    c = cyc; drv(OP_ANDI, 1'b1); expD(c, 1, 0, 0, 0, 0, 1); expE(c + 1, 1, 1, 0, 0, 0, 3); tick();
    c = cyc; drv(OP_SLTI, 1'b1); expD(c, 1, 0, 0, 0, 0, 0); expE(c + 1, 1, 1, 0, 0, 0, 5); tick();
    c = cyc; drv(OP_LUI, 1'b1);  expD(c, 1, 0, 0, 0, 0, 0); expE(c + 1, 1, 1, 0, 0, 0, 6); tick();
    c = cyc; drv(OP_J, 1'b1);    expD(c, 0, 0, 0, 1, 0, 0); expE(c + 1, 0, 0, 0, 0, 0, 0); tick();
    c = cyc; drv(OP_ADDI, 1'b1); expD(c, 1, 0, 0, 0, 0, 0); expE(c + 1, 1, 1, 0, 0, 0, 0); tick();
    c = cyc; drv(OP_JAL, 1'b0);  expD(c, 0, 0, 0, 0, 0, 0); expE(c + 1, 0, 0, 0, 0, 0, 0); tick();
    drv(6'd0, 1'b0);
    tick(4);

    // LW held in EX for two cycles: two bubbles into MEM, WB two cycles late
    c = cyc;
    drv(OP_LW, 1'b1);
    expE(c + 1, 1, 1, 1, 0, 0, 0); ex(c + 2, S_RWE, 1); ex(c + 3, S_RWE, 1); ex(c + 4, S_RWE, 0);
    ex(c + 2, S_RWM, 0); ex(c + 3, S_RWM, 0); ex(c + 4, S_RWM, 1); ex(c + 4, S_MRM, 1);
    ex(c + 3, S_RWW, 0); ex(c + 4, S_RWW, 0); ex(c + 5, S_RWW, 1); ex(c + 5, S_MRW, 1);
    tick();
    drv(6'd0, 1'b0, 1'b1); tick();
    drv(6'd0, 1'b0, 1'b1); tick();
    drv(6'd0, 1'b0);
    tick(4);

    // flushE together with stallE clears ID/EX
    c = cyc;
    drv(OP_ADDI, 1'b1);
    ex(c + 1, S_RWE, 1); expE(c + 2, 0, 0, 0, 0, 0, 0); ex(c + 2, S_RWM, 0); ex(c + 3, S_RWW, 0);
    tick();
    drv(OP_R, 1'b1, 1'b1, 1'b1); tick();
    drv(6'd0, 1'b0);
    tick(4);

    // stallM holds EX/MEM even with stallE; flushM beats stallM
    c = cyc;
    drv(OP_LW, 1'b1);
    ex(c + 2, S_MRM, 1); ex(c + 3, S_MRM, 1); ex(c + 3, S_RWW, 1);
    ex(c + 4, S_RWM, 0); ex(c + 4, S_MRW, 1); ex(c + 5, S_RWW, 0);
    tick();
    drv(6'd0, 1'b0); tick();
    drv(6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    drv(6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    drv(6'd0, 1'b0);
    tick(4);

    // Illegal op held by stallE is counted once
    c = cyc;
    drv(6'h3F, 1'b1);
    expD(c, 0, 0, 0, 0, 0, 0); ex(c + 1, S_RWE, 0);
    ex(c, S_ILLCNT, 0); ex(c + 1, S_ILLCNT, 1); ex(c + 2, S_ILLCNT, 1); ex(c + 3, S_ILLCNT, 2); ex(c + 5, S_ILLCNT, 2);
    ex(c + 3, S_ILLW, 0); ex(c + 4, S_ILLW, 1);
    tick();
    drv(6'h3F, 1'b1, 1'b1); tick();
    drv(6'h3F, 1'b1); tick();
    drv(6'd0, 1'b0);
    tick(4);

    // Asynchronous reset mid-stream with ADDI in every stage
    c = cyc;
    drv(OP_ADDI, 1'b1);
    ex(c + 3, S_RWE, 1); ex(c + 3, S_RWM, 1); ex(c + 3, S_RWW, 1);
    ex(c + 4, S_RWE, 0); ex(c + 4, S_ASE, 0); ex(c + 4, S_RWM, 0); ex(c + 4, S_RWW, 0);
    ex(c + 4, S_ILLW, 0); ex(c + 4, S_ILLCNT, 0); ex(c + 4, S_RWD, 1);
    ex(c + 5, S_RWE, 0); expE(c + 6, 1, 0, 0, 0, 1, 2); ex(c + 7, S_RWM, 1); ex(c + 8, S_RWW, 1);
    tick(4);
    rst = 1'b1;
    #1;
    nChecks++;
    if (bus.regwriteE !== 1'b0) begin
      nFails++;
      $display("FAIL regwriteE not cleared immediately by async reset: got %0d", bus.regwriteE);
    end
    nChecks++;
    if (bus.regwriteM !== 1'b0) begin
      nFails++;
      $display("FAIL regwriteM not cleared immediately by async reset: got %0d", bus.regwriteM);
    end
    nChecks++;
    if (bus.regwriteW !== 1'b0) begin
      nFails++;
      $display("FAIL regwriteW not cleared immediately by async reset: got %0d", bus.regwriteW);
    end
    nChecks++;
    if (bus.regwriteD !== 1'b1) begin
      nFails++;
      $display("FAIL regwriteD should follow opD during reset: got %0d", bus.regwriteD);
    end
    tick();
    rst = 1'b0;
    drv(OP_R, 1'b1);
    tick();
    drv(6'd0, 1'b0);
    tick(4);

    // Eight illegal ops with a 2-bit counter: saturates at 3, illegalW sticky
    c = cyc;
    drv(6'h3F, 1'b1);
    expD(c, 0, 0, 0, 0, 0, 0);
    ex(c, S_ILLCNT, 0); ex(c + 1, S_ILLCNT, 1); ex(c + 2, S_ILLCNT, 2); ex(c + 3, S_ILLCNT, 3);
    ex(c + 5, S_ILLCNT, 3); ex(c + 8, S_ILLCNT, 3); ex(c + 12, S_ILLCNT, 3);
    ex(c + 2, S_ILLW, 0); ex(c + 3, S_ILLW, 1); ex(c + 12, S_ILLW, 1);
    tick(8);
    drv(6'd0, 1'b0);
    tick(6);

    nChecks++;
    if (bus.illcnt !== 2'd3) begin
      nFails++;
      $display("FAIL illcnt after saturation: got %0d, expected 3", bus.illcnt);
    end
    nChecks++;
    if (bus.illegalW !== 1'b1) begin
      nFails++;
      $display("FAIL illegalW not sticky: got %0d, expected 1", bus.illegalW);
    end

    while (sb.size() > 0) begin
      nChecks++;
      nFails++;
      $display("FAIL unchecked %s: expected %0d at cycle %0d, run ended at cycle %0d",
               sigName(sb[0].sig), sb[0].val, sb[0].at, cyc);
      void'(sb.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
